// File: rtl/fetch_pkg.sv
// Shared fetch types and constants: state encoding, word geometry, big-endian byte-lane placement.
// No logic and no latency of its own.
// Backpressure: not applicable.
package fetch_pkg;

   localparam int          BYTES_PER_INSTR  = 4;
   localparam int          BYTE_W           = 8;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {FETCH, HOLD} fetch_state_t;

   // MSB of the lane for byte k of a word: the lowest address lands in the top byte.
   function automatic logic [4:0] lane_msb(input logic [1:0] k);
      return 5'((BYTES_PER_INSTR - int'(k)) * BYTE_W - 1);
   endfunction

endpackage

// File: rtl/fetch_word_fifo.sv
// Two-entry word+pc queue between the byte assembler and decode; present only with ROM_FETCH_PREFETCH_EN.
// Latency: a pushed entry is visible at the head the next cycle.
// Backpressure: caller holds push off when full unless also popping; flush empties both entries.
`ifdef ROM_FETCH_PREFETCH_EN
module fetch_word_fifo #(
   parameter int W = 64
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] pop_dat,
   output logic [1:0]   count
);
   logic [W-1:0] mem_q [2];
   logic         wr_q, rd_q;
   logic [1:0]   cnt_q;

   assign pop_dat = mem_q[rd_q];
   assign count   = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else if (flush) begin
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= push_dat;
            wr_q        <= ~wr_q;
         end
         if (pop)
            rd_q <= ~rd_q;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: ;
         endcase
      end
   end
endmodule
`endif

// File: rtl/rom_fetch_unit.sv
// Fetch stage: walks the byte-wide ROM and assembles big-endian 32-bit words; ROM_FETCH_PREFETCH_EN adds a 2-word queue.
// Latency: 5 cycles from first byte address to instr_valid; without the queue one word per handshake+5 cycles.
// Backpressure: instr_ready low holds the word (or fills the queue) and stops address issue; redirect overrides all.
module rom_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    BUS_WIDTH   = 8,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT)
)(
   input  logic                   clk,
   input  logic                   rst_n,
   output logic [ADDR_WIDTH-1:0]  rom_addr,
   input  logic [BUS_WIDTH-1:0]   rom_data,
   input  logic                   redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [INSTR_WIDTH-1:0] instr_data,
   output logic [ADDR_WIDTH-1:0]  instr_pc,
   output logic                   align_err
);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(BYTES_PER_INSTR);

   fetch_state_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0]  rom_addr_q, word_pc_q, redir_base;
   logic [2:0]             iss_cnt_q, iss_cnt_d;
   logic [1:0]             cap_cnt_q;
   logic                   tag_q, align_err_q;
   logic                   issue_en, cap_last, handshake, word_adv;
   logic [INSTR_WIDTH-1:0] asm_q, asm_d;

   assign redir_base = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   assign cap_last   = tag_q && (cap_cnt_q == 2'd3);
   assign handshake  = instr_valid && instr_ready;
   assign rom_addr   = rom_addr_q;
   assign align_err  = align_err_q;

`ifdef ROM_FETCH_PREFETCH_EN
   logic [1:0]                        fifo_cnt;
   logic [2:0]                        occ;
   logic                              pend, credit_ok;
   logic [INSTR_WIDTH+ADDR_WIDTH-1:0] head_dat;

   // A word still being assembled owns a queue slot, so starting a new word never overflows.
   assign pend      = tag_q || (cap_cnt_q != 2'd0);
   assign occ       = {1'b0, fifo_cnt} + {2'b00, pend} - {2'b00, handshake};
   assign credit_ok = occ < 3'd2;
   assign word_adv  = cap_last;

   fetch_word_fifo #(.W(INSTR_WIDTH + ADDR_WIDTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .push     (cap_last && !redirect_valid),
      .push_dat ({asm_d, word_pc_q}),
      .pop      (handshake),
      .pop_dat  (head_dat),
      .count    (fifo_cnt)
   );

   assign instr_valid = (fifo_cnt != 2'd0);
   assign instr_data  = head_dat[INSTR_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
   assign instr_pc    = head_dat[ADDR_WIDTH-1:0];
`else
   logic                   valid_q;
   logic [INSTR_WIDTH-1:0] data_q;
   logic [ADDR_WIDTH-1:0]  pc_q;

   assign word_adv    = (state_q == HOLD) && instr_ready;
   assign instr_valid = valid_q;
   assign instr_data  = data_q;
   assign instr_pc    = pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         pc_q    <= '0;
      end else if (redirect_valid) begin
         valid_q <= 1'b0;
      end else if (cap_last) begin
         valid_q <= 1'b1;
         data_q  <= asm_d;
         pc_q    <= word_pc_q;
      end else if (handshake) begin
         valid_q <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (redirect_valid)
         state_d = FETCH;
      else
         case (state_q)
`ifdef ROM_FETCH_PREFETCH_EN
            FETCH: if (iss_cnt_q == 3'd3) state_d = HOLD;
            HOLD:  if (credit_ok)         state_d = FETCH;
`else
            FETCH: if (cap_last)    state_d = HOLD;
            HOLD:  if (instr_ready) state_d = FETCH;
`endif
         endcase
   end

   always_comb begin
      issue_en  = 1'b0;
      iss_cnt_d = iss_cnt_q;
      case (state_q)
`ifdef ROM_FETCH_PREFETCH_EN
         FETCH: begin
            issue_en  = 1'b1;
            iss_cnt_d = (iss_cnt_q == 3'd3) ? 3'd0 : iss_cnt_q + 3'd1;
         end
         HOLD: if (credit_ok) begin
            issue_en  = 1'b1;
            iss_cnt_d = 3'd1;
         end
`else
         // After four issues rom_addr parks on base+4 until decode takes the word.
         FETCH: if (!iss_cnt_q[2]) begin
            issue_en  = 1'b1;
            iss_cnt_d = iss_cnt_q + 3'd1;
         end
         HOLD: if (instr_ready) iss_cnt_d = 3'd0;
`endif
      endcase
   end

   always_comb begin
      asm_d = asm_q;
      asm_d[lane_msb(cap_cnt_q) -: BUS_WIDTH] = rom_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr_q  <= RESET_PC;
         word_pc_q   <= RESET_PC;
         iss_cnt_q   <= 3'd0;
         cap_cnt_q   <= 2'd0;
         tag_q       <= 1'b0;
         asm_q       <= '0;
         align_err_q <= 1'b0;
      end else begin
         align_err_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
         if (redirect_valid) begin
            // Clearing the tag drops whichever ROM byte arrives next.
            rom_addr_q <= redir_base;
            word_pc_q  <= redir_base;
            iss_cnt_q  <= 3'd0;
            cap_cnt_q  <= 2'd0;
            tag_q      <= 1'b0;
         end else begin
            tag_q     <= issue_en;
            iss_cnt_q <= iss_cnt_d;
            if (issue_en)
               rom_addr_q <= rom_addr_q + ADDR_ONE;
            if (tag_q) begin
               asm_q     <= asm_d;
               cap_cnt_q <= cap_cnt_q + 2'd1;
            end
            if (word_adv)
               word_pc_q <= word_pc_q + WORD_STEP;
         end
      end
   end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit: ROM model with one-cycle read latency, hand-computed expectations.
module tb_rom_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] rom_addr;
   logic [7:0]  rom_data = 8'h00;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        align_err;

   logic [7:0]  rom [256];
   int          checks = 0;
   int          errors = 0;
   int          n;

   rom_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .align_err      (align_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr[7:0]];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      instr_ready    = rdy;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick;
      redirect_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      do begin
         tick;
         cyc++;
      end while (!instr_valid && cyc < 20);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 8'(i);
      rom[0] = 8'h3C; rom[1] = 8'h08; rom[2] = 8'h12; rom[3] = 8'h34;
      rom[4] = 8'h35; rom[5] = 8'h08; rom[6] = 8'h56; rom[7] = 8'h78;

      // Straight-line fetch with ready high
      do_reset(1'b1);
      chk("rst_addr",  rom_addr,    32'h0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_data",  instr_data,  32'h0);
      chk("rst_pc",    instr_pc,    32'h0);
      chk("rst_align", align_err,   1'b0);
      tick; chk("addr1", rom_addr, 32'h1);
      tick; chk("addr2", rom_addr, 32'h2);
      tick; chk("addr3", rom_addr, 32'h3);
      tick; chk("c4_valid", instr_valid, 1'b0);
      tick;
      chk("w0_valid", instr_valid, 1'b1);
      chk("w0_data",  instr_data,  32'h3C081234);
      chk("w0_pc",    instr_pc,    32'h0);
      tick;
      chk("post_hs_valid", instr_valid, 1'b0);
      chk("post_hs_addr",  rom_addr,    32'h4);
      wait_valid(n);
      chk("w1_lat",  n,          5);
      chk("w1_data", instr_data, 32'h35085678);
      chk("w1_pc",   instr_pc,   32'h4);

      // Backpressure: word held, address parked on base+4
      do_reset(1'b0);
      wait_valid(n);
      chk("bp_w0_lat", n, 5);
      for (int i = 0; i < 10; i++) begin
         tick;
         chk("bp_valid", instr_valid, 1'b1);
         chk("bp_data",  instr_data,  32'h3C081234);
         chk("bp_pc",    instr_pc,    32'h0);
         chk("bp_addr",  rom_addr,    32'h4);
      end
      instr_ready = 1'b1;
      tick;
      chk("bp_rel_valid", instr_valid, 1'b0);
      wait_valid(n);
      chk("bp_w1_lat",  n,          5);
      chk("bp_w1_data", instr_data, 32'h35085678);
      chk("bp_w1_pc",   instr_pc,   32'h4);

      // Redirect while byte 2 of word 0 is in flight
      do_reset(1'b1);
      tick; tick; tick;
      redirect(32'h40);
      chk("rd_addr",  rom_addr,    32'h40);
      chk("rd_align", align_err,   1'b0);
      chk("rd_valid", instr_valid, 1'b0);
      wait_valid(n);
      chk("rd_lat",  n,          5);
      chk("rd_pc",   instr_pc,   32'h40);
      chk("rd_data", instr_data, 32'h40414243);

      // Misaligned redirect
      do_reset(1'b1);
      tick;
      redirect(32'h42);
      chk("mis_align1", align_err, 1'b1);
      chk("mis_addr",   rom_addr,  32'h40);
      tick;
      chk("mis_align0", align_err, 1'b0);
      wait_valid(n);
      chk("mis_lat",  n,          4);
      chk("mis_pc",   instr_pc,   32'h40);
      chk("mis_data", instr_data, 32'h40414243);

      // Redirect in the same cycle as an accepted handshake
      do_reset(1'b1);
      wait_valid(n);
      chk("hsr_w0_data", instr_data, 32'h3C081234);
      redirect(32'h44);
      chk("hsr_valid", instr_valid, 1'b0);
      chk("hsr_addr",  rom_addr,    32'h44);
      wait_valid(n);
      chk("hsr_lat",  n,          5);
      chk("hsr_pc",   instr_pc,   32'h44);
      chk("hsr_data", instr_data, 32'h44454647);

      // PC wrap from the top of the address space
      do_reset(1'b1);
      redirect(32'hFFFF_FFFC);
      wait_valid(n);
      chk("wrap_lat",  n,          5);
      chk("wrap_pc",   instr_pc,   32'hFFFF_FFFC);
      chk("wrap_data", instr_data, 32'hFCFDFEFF);
      tick;
      chk("wrap_addr", rom_addr, 32'h0);
      wait_valid(n);
      chk("wrap_next_pc",   instr_pc,   32'h0);
      chk("wrap_next_data", instr_data, 32'h3C081234);

      // Asynchronous reset while holding a word
      do_reset(1'b0);
      wait_valid(n);
      tick; tick;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", instr_valid, 1'b0);
      chk("arst_data",  instr_data,  32'h0);
      chk("arst_pc",    instr_pc,    32'h0);
      chk("arst_addr",  rom_addr,    32'h0);
      chk("arst_align", align_err,   1'b0);
      instr_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      wait_valid(n);
      chk("arst_lat",  n,          5);
      chk("arst_pc2",  instr_pc,   32'h0);
      chk("arst_data2", instr_data, 32'h3C081234);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
